segment_scan_controller: RTL and testbench
==========================================

# segment_scan_controller

Time-multiplexed scan controller for the multi-digit 7-segment display. It holds DIGITS BCD digits, drives one shared BCD-to-7-segment decoder with one digit at a time, and asserts the matching one-hot digit select. Digit updates are double-buffered so a frame is never torn, and a one-cycle blanking gap between digits prevents ghosting.

## Interface
- DIGITS, 4: number of digits scanned (2..8).
- DIV, 1000: clock cycles each digit is driven per slot (≥2).
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, asynchronous, active-low.
- en  input  1  scan enable; 0 forces IDLE.
- load  input  1  one-cycle strobe; captures bcd_in into shadow register.
- bcd_in  input  4*DIGITS  digit i = bcd_in[4i+3:4i]; digit 0 is least significant.
- num_out  output  4  BCD value to the shared decoder.
- blank_out  output  1  1 = decoder output must be ignored or off.
- dig_sel  output  DIGITS  one-hot digit enable, active-high.
- frame_done  output  1  one-cycle pulse at each frame wrap.

## Operation
- Registers: shadow[4*DIGITS], active[4*DIGITS], pending flag, scan index idx, prescaler cnt (0..DIV-1), state.
- States: IDLE, BLANK, DRIVE.
- IDLE: dig_sel=0, blank_out=1, idx=0, cnt=0; if pending, shadow→active and pending cleared each cycle. en=1 → BLANK next cycle.
- BLANK: exactly 1 cycle; dig_sel=0, blank_out=1, num_out holds the previous value → DRIVE.
- DRIVE: dig_sel=1<<idx, num_out=active[idx], blank_out=0; lasts DIV cycles (cnt 0..DIV-1). At cnt=DIV-1: idx+1 → BLANK; if idx=DIGITS-1, wrap to 0 and this is the frame boundary.
- Frame boundary: frame_done=1 for 1 cycle (the following BLANK cycle); if pending, shadow→active and pending cleared.
- load: shadow←bcd_in and pending←1 in any state.
- Load coinciding with the boundary: the old shadow value transfers to active, the new value goes to shadow, and pending stays 1.
- en=0 in any state: IDLE next cycle; the current digit is abandoned. en is sampled every cycle.
- Values 10..15 pass through unchanged; the decoder shows a dash.

## Timing
- Reset values: num_out=0, blank_out=1, dig_sel=0, frame_done=0, state=IDLE, idx=0, cnt=0, shadow=0, active=0, pending=0.
- All outputs are registered.
- Frame period is DIGITS*(DIV+1) cycles.
- en rises at cycle t: BLANK at t+1, digit 0 driven from t+2.
- Load latency:
  - Load during a scan appears at the first digit-0 DRIVE after the next frame boundary.
  - Load in IDLE reaches active on the next cycle.
- Reset mid-scan: outputs take their reset values immediately, independent of clk.

## Configuration
- LEADING_ZERO_BLANK_EN defined: in DRIVE, digit i>0 is suppressed when active digits i..DIGITS-1 are all 0. A suppressed digit has dig_sel=0 and blank_out=1, with slot length unchanged. Digit 0 is never suppressed. Evaluated on active, not shadow.
- Undefined: every digit is driven, zeros included.

## Test plan
- Reset: rst=0 with clk running → num_out=0, blank_out=1, dig_sel=0, frame_done=0. Outputs hold after release until en=1.
- Scan order (DIGITS=4, DIV=3): load 0x1234 in IDLE, en=1. Expected sequence, each DRIVE 3 cycles separated by 1 BLANK cycle:
  - 4 with dig_sel=0001
  - 3 with 0010
  - 2 with 0100
  - 1 with 1000
  - frame_done pulses every 16 cycles.
- No tearing: load 0x5678 while digit 1 is driven → digits 2 and 3 still show 2 and 1; 8,7,6,5 appear from the next frame.
- Boundary collision: load 0x1111 mid-frame, then load 0x2222 exactly at the boundary cycle → next frame shows 1111, the following frame shows 2222.
- en drop: en=0 mid-DRIVE of digit 2 → next cycle dig_sel=0, blank_out=1. Re-enable restarts at digit 0 after 1 BLANK cycle.
- With LEADING_ZERO_BLANK_EN, load 0x0040:
  - digits 3 and 2 slots have dig_sel=0, blank_out=1
  - digit 1 shows 4, digit 0 shows 0
  - load 0x0000 → only digit 0 is lit, showing 0.

Source files
------------

// File: rtl/segment_scan_controller_if.sv
// Handshake/bus bundle for segment_scan_controller.
//   master: drives en, load, bcd_in; observes the display outputs.
//   slave : the scan controller itself.
// Signals:
//   en         scan enable
//   load       one-cycle strobe capturing bcd_in into the shadow buffer
//   bcd_in     DIGITS packed BCD digits, digit 0 in bits [3:0]
//   num_out    BCD value for the shared decoder
//   blank_out  1 = decoder output must be ignored/off
//   dig_sel    one-hot active-high digit enable
//   frame_done one-cycle pulse at each frame wrap
interface segment_scan_controller_if #(
   parameter int DIGITS = 4
) ();
   logic                  en;
   logic                  load;
   logic [4*DIGITS-1:0]   bcd_in;
   logic [3:0]            num_out;
   logic                  blank_out;
   logic [DIGITS-1:0]     dig_sel;
   logic                  frame_done;

   modport master (
      output en, load, bcd_in,
      input  num_out, blank_out, dig_sel, frame_done
   );

   modport slave (
      input  en, load, bcd_in,
      output num_out, blank_out, dig_sel, frame_done
   );
endinterface

// File: rtl/segment_scan_controller.sv
// Time-multiplexed 7-segment scan controller.
// Scans DIGITS BCD digits through one shared decoder, one digit per slot of
// DIV cycles, with a one-cycle blanking gap before every digit. New digit
// values land in a shadow buffer and are copied to the active buffer only in
// IDLE or at a frame wrap, so a frame is never torn.
// Ports:
//   clk  system clock, rising edge
//   rst  asynchronous active-low reset
//   bus  segment_scan_controller_if.slave (en, load, bcd_in in;
//        num_out, blank_out, dig_sel, frame_done out, all registered)
// Optional feature: define LEADING_ZERO_BLANK_EN to suppress leading zero
// digits (digit 0 always shown).
module segment_scan_controller #(
   parameter int DIGITS = 4,
   parameter int DIV    = 1000
) (
   input logic                      clk,
   input logic                      rst,
   segment_scan_controller_if.slave bus
);
   localparam int            IW       = $clog2(DIGITS);
   localparam int            CW       = $clog2(DIV);
   localparam logic [IW-1:0] LAST_IDX = IW'(DIGITS - 1);
   localparam logic [CW-1:0] LAST_CNT = CW'(DIV - 1);

   typedef enum logic [1:0] {IDLE, BLANK, DRIVE} state_t;

   state_t                 state;
   logic [DIGITS-1:0][3:0] shadow;
   logic [DIGITS-1:0][3:0] active;
   logic                   pending;
   logic [IW-1:0]          idx;
   logic [CW-1:0]          cnt;
   logic [3:0]             num_r;
   logic                   blank_r;
   logic [DIGITS-1:0]      sel_r;
   logic                   fd_r;

   logic wrap;
   logic xfer;
   logic supp;

   // Last DRIVE cycle of the last digit with scanning still enabled; an en
   // drop on this edge abandons the frame instead of completing it.
   assign wrap = (state == DRIVE) && (cnt == LAST_CNT) && (idx == LAST_IDX) && bus.en;
   assign xfer = pending && ((state == IDLE) || wrap);

`ifdef LEADING_ZERO_BLANK_EN
   // zero_up[i]: active digits i..DIGITS-1 are all zero.
   logic [DIGITS-1:0] zero_up;
   always_comb begin
      logic acc;
      zero_up = '0;
      acc     = 1'b1;
      for (int i = DIGITS - 1; i >= 0; i--) begin
         acc        = acc && (active[i] == 4'd0);
         zero_up[i] = acc;
      end
   end
   assign supp = (idx != '0) && zero_up[idx];
`else
   assign supp = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= IDLE;
         shadow  <= '0;
         active  <= '0;
         pending <= 1'b0;
         idx     <= '0;
         cnt     <= '0;
         num_r   <= 4'd0;
         blank_r <= 1'b1;
         sel_r   <= '0;
         fd_r    <= 1'b0;
      end else begin
         fd_r <= 1'b0;

         // A load on the transfer edge moves the old shadow and keeps
         // pending set for the new value (second assignment wins).
         if (xfer) begin
            active  <= shadow;
            pending <= 1'b0;
         end
         if (bus.load) begin
            shadow  <= bus.bcd_in;
            pending <= 1'b1;
         end

         if (!bus.en) begin
            state   <= IDLE;
            idx     <= '0;
            cnt     <= '0;
            sel_r   <= '0;
            blank_r <= 1'b1;
         end else begin
            case (state)
               IDLE: begin
                  state <= BLANK;
               end
               BLANK: begin
                  // active only changes on the wrap edge, so it is settled here
                  state   <= DRIVE;
                  cnt     <= '0;
                  num_r   <= active[idx];
                  sel_r   <= supp ? '0 : (DIGITS'(1) << idx);
                  blank_r <= supp;
               end
               DRIVE: begin
                  if (cnt == LAST_CNT) begin
                     state   <= BLANK;
                     cnt     <= '0;
                     sel_r   <= '0;
                     blank_r <= 1'b1;
                     if (idx == LAST_IDX) begin
                        idx  <= '0;
                        fd_r <= 1'b1;
                     end else begin
                        idx <= idx + 1'b1;
                     end
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

   assign bus.num_out    = num_r;
   assign bus.blank_out  = blank_r;
   assign bus.dig_sel    = sel_r;
   assign bus.frame_done = fd_r;
endmodule

// File: tb/tb_segment_scan_controller.sv
// Scoreboard bench for segment_scan_controller (DIGITS=4, DIV=3).
// A reference model derives every cycle's expected outputs from the frame
// position (frame = DIGITS slots of one blank cycle + DIV drive cycles) and
// pushes them into a queue; a monitor on the falling edge pops and compares.
module tb_segment_scan_controller;
   localparam int DIGITS = 4;
   localparam int DIV    = 3;
   localparam int SLOT   = DIV + 1;
   localparam int PERIOD = DIGITS * SLOT;

   typedef struct packed {
      logic [3:0]        num;
      logic              blank;
      logic [DIGITS-1:0] sel;
      logic              fd;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   segment_scan_controller_if #(.DIGITS(DIGITS)) bus ();

   segment_scan_controller #(.DIGITS(DIGITS), .DIV(DIV)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int total  = 0;
   int passed = 0;
   int cyc    = 0;
   exp_t q[$];

   // ---------------- reference model ----------------
   bit         m_on;
   int         m_pos;
   bit         m_pend;
   logic [3:0] m_act[DIGITS];
   logic [3:0] m_sh[DIGITS];
   logic [3:0] m_num;

   function automatic bit suppressed(input int k);
`ifdef LEADING_ZERO_BLANK_EN
      if (k == 0) return 1'b0;
      for (int j = k; j < DIGITS; j++) if (m_act[j] != 4'd0) return 1'b0;
      return 1'b1;
`else
      return (k < 0);
`endif
   endfunction

   always @(posedge clk) begin
      exp_t e;
      bit   fd;
      bit   was_idle;
      cyc++;
      if (!rst) begin
         m_on = 0; m_pos = 0; m_pend = 0; m_num = 4'd0;
         for (int i = 0; i < DIGITS; i++) begin m_act[i] = 4'd0; m_sh[i] = 4'd0; end
         e = '{num: 4'd0, blank: 1'b1, sel: '0, fd: 1'b0};
      end else begin
         was_idle = !m_on;
         fd = m_on && bus.en && (m_pos == PERIOD - 1);
         if ((was_idle || fd) && m_pend) begin
            for (int i = 0; i < DIGITS; i++) m_act[i] = m_sh[i];
            m_pend = 0;
         end
         if (bus.load) begin
            for (int i = 0; i < DIGITS; i++) m_sh[i] = bus.bcd_in[4*i +: 4];
            m_pend = 1;
         end
         if (!bus.en) m_on = 0;
         else if (!m_on) begin m_on = 1; m_pos = 0; end
         else m_pos = (m_pos + 1) % PERIOD;
         e.fd = fd; e.sel = '0; e.blank = 1'b1;
         if (m_on && (m_pos % SLOT) != 0) begin
            int k;
            k = m_pos / SLOT;
            m_num = m_act[k];
            if (!suppressed(k)) begin
               e.sel   = DIGITS'(1) << k;
               e.blank = 1'b0;
            end
         end
         e.num = m_num;
      end
      q.push_back(e);
   end

   // ---------------- monitor ----------------
   always @(negedge clk) begin
      if (q.size() > 0) begin
         exp_t e, a;
         e = q.pop_front();
         a = '{num: bus.num_out, blank: bus.blank_out, sel: bus.dig_sel, fd: bus.frame_done};
         total++;
         if (a === e) passed++;
         else $display("FAIL outputs@cyc%0d: got num=%0h blank=%0b sel=%b fd=%0b, want num=%0h blank=%0b sel=%b fd=%0b",
                       cyc, a.num, a.blank, a.sel, a.fd, e.num, e.blank, e.sel, e.fd);
      end
   end

   // ---------------- stimulus ----------------
   task automatic set(input logic e, input logic l, input logic [15:0] b);
      bus.en = e; bus.load = l; bus.bcd_in = b;
   endtask

   task automatic drive(input logic e, input logic l, input logic [15:0] b);
      @(negedge clk); #1;
      set(e, l, b);
   endtask

   task automatic run(input int n, input logic e);
      for (int i = 0; i < n; i++) drive(e, 1'b0, 16'h0);
   endtask

   // Leaves us just after a falling edge in the first cycle dig_sel==t,
   // with the inputs for the coming edge not yet set.
   task automatic wait_sel(input logic [DIGITS-1:0] t);
      int n;
      n = 0;
      forever begin
         @(negedge clk); #1;
         if (bus.dig_sel == t) break;
         set(1'b1, 1'b0, 16'h0);
         n++;
         if (n > 4 * PERIOD) begin
            total++;
            $display("FAIL wait_sel: dig_sel=%b never reached, want %b", bus.dig_sel, t);
            break;
         end
      end
   endtask

   task automatic check_reset(input string name);
      total++;
      if (bus.num_out === 4'd0 && bus.blank_out === 1'b1 && bus.dig_sel === '0 && bus.frame_done === 1'b0)
         passed++;
      else
         $display("FAIL %s: got num=%0h blank=%0b sel=%b fd=%0b, want num=0 blank=1 sel=0000 fd=0",
                  name, bus.num_out, bus.blank_out, bus.dig_sel, bus.frame_done);
   endtask

   initial begin
      set(1'b0, 1'b0, 16'h0);
      // reset with clock running, then idle with en=0
      repeat (3) @(negedge clk);
      #1 check_reset("reset_hold");
      rst = 1'b1;
      run(4, 1'b0);

      // scan order
      drive(1'b0, 1'b1, 16'h1234);
      run(2 * PERIOD + 3, 1'b1);

      // no tearing: load while digit 1 is driven
      wait_sel(4'b0010);
      set(1'b1, 1'b1, 16'h5678);
      run(2 * PERIOD, 1'b1);

      // boundary collision
      wait_sel(4'b0010);
      set(1'b1, 1'b1, 16'h1111);
      wait_sel(4'b1000);
      set(1'b1, 1'b0, 16'h0);
      for (int i = 0; i < DIV - 2; i++) drive(1'b1, 1'b0, 16'h0);
      drive(1'b1, 1'b1, 16'h2222);
      run(3 * PERIOD, 1'b1);

      // en drop mid-DRIVE of digit 2, then re-enable
      wait_sel(4'b0100);
      set(1'b1, 1'b0, 16'h0);
      drive(1'b0, 1'b0, 16'h0);
      run(3, 1'b0);
      run(PERIOD + 4, 1'b1);

      // asynchronous reset mid-scan
      wait_sel(4'b0001);
      set(1'b1, 1'b0, 16'h0);
      rst = 1'b0;
      #1 check_reset("async_reset");
      run(2, 1'b1);
      rst = 1'b1;
      run(PERIOD, 1'b1);

      // leading-zero patterns (plain scan when the option is off)
      drive(1'b0, 1'b0, 16'h0);
      drive(1'b0, 1'b1, 16'h0040);
      run(2 * PERIOD + 2, 1'b1);
      wait_sel(4'b0001);
      set(1'b1, 1'b1, 16'h0000);
      run(2 * PERIOD + 2, 1'b1);

      // randomized traffic
      for (int i = 0; i < 800; i++) begin
         logic [15:0] b;
         for (int d = 0; d < DIGITS; d++)
            b[4*d +: 4] = ($urandom_range(2) == 0) ? 4'd0 : 4'($urandom_range(15));
         drive(($urandom_range(99) < 95), ($urandom_range(99) < 6), b);
      end
      run(4, 1'b1);

      @(negedge clk); #1;
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
